sync_fifo_flags: RTL and testbench
==================================

# sync_fifo_flags

Parametrised single-clock FIFO, successor to the team's basic synchronous FIFO. Adds any depth (not only powers of two), exported full/empty, programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, a read-valid strobe, and an optional first-word-fall-through read mode. Used as the general-purpose buffer between producer and consumer blocks in one clock domain.

## Interface
- DATA_WIDTH, 16, width of each stored word
- DEPTH, 16, number of storage entries; any integer >= 2
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1
- CW (localparam), $clog2(DEPTH+1), count width; PW (localparam), $clog2(DEPTH), pointer width

- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- w_en  in  1  write request
- d_in  in  DATA_WIDTH  write data
- r_en  in  1  read request
- clr_err  in  1  synchronous clear of overflow/underflow
- d_out  out  DATA_WIDTH  read data
- d_valid  out  1  d_out carries a newly read word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  CW  stored words, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Write accepted (wr_ok) = w_en & !full; read accepted (rd_ok) = r_en & !empty. full/empty are the registered values at the current edge.
- wr_ok: mem[w_ptr] <= d_in; w_ptr advances, wraps DEPTH-1 -> 0.
- rd_ok: r_ptr advances, wraps DEPTH-1 -> 0.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. Never exceeds DEPTH or drops below 0.
- full, empty, almost_full, almost_empty derive only from count; all reflect the post-update count the cycle after the edge.
- Simultaneous w_en & r_en:
  - count 1..DEPTH-1: both accepted, count unchanged.
  - full: read accepted, write dropped, overflow set; count becomes DEPTH-1.
  - empty: write accepted, read rejected, underflow set; count becomes 1.
- overflow set on w_en & full; underflow set on r_en & empty. Both hold until clr_err or reset. If clr_err and a new error coincide, the flag stays set.
- Dropped writes never modify mem or w_ptr; rejected reads never modify r_ptr, d_out or d_valid.
- Reset (at any time, including mid-burst): w_ptr = r_ptr = 0, count = 0, empty = 1, almost_empty = 1, full = almost_full = 0 (almost_full = 0 unless AF_LEVEL == 0), overflow = underflow = 0, d_out = 0, d_valid = 0. Memory contents are not reset and are unobservable.

## Timing
- Standard mode: rd_ok at edge N -> d_out = mem[old r_ptr] and d_valid = 1 after edge N; d_valid is low in cycles without rd_ok; d_out holds its last value.
- Write-to-read latency: a word written at edge N can be read at edge N+1 (empty deasserts after edge N).
- Flags and count: updated at the same edge as the access, no extra pipeline stage.
- Full throughput: one write and one read per cycle sustained.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through. d_out = mem[r_ptr] combinationally; d_valid = !empty. rd_ok pops the presented word; the next word appears after the same edge. Read latency 0. Reset: d_valid = 0, d_out undefined until first write.
- Undefined: standard registered read as described in Timing.

## Test plan
- Reset then write 0x0001..0x0010 (16 words) -> count 16, full = 1, almost_full set at count 14; read 16 -> d_out 0x0001..0x0010 in order, each one cycle after r_en, empty = 1.
- Full FIFO, w_en = 1 with d_in = 0xDEAD -> word dropped, overflow = 1, count stays 16; clr_err pulse -> overflow = 0.
- Empty FIFO, r_en = 1 -> underflow = 1, d_valid = 0, d_out unchanged.
- DEPTH = 5, 12 write/read cycles -> pointers wrap; data order preserved; count never exceeds 5.
- Count 8, w_en & r_en together for 20 cycles -> count stays 8, 20 d_valid pulses, data in order; full with both -> count 15, overflow = 1.
- Write 3 words, assert resetn low mid-burst -> all outputs at reset values immediately; post-reset read -> underflow = 1.

Source files
------------

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// sync_fifo_flags : single-clock FIFO of any depth with count, threshold and
// sticky error flags; optional first-word-fall-through via SYNC_FIFO_FWFT_EN.
// Revision 1.0
// ============================================================================
module sync_fifo_flags #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2,
   localparam int CW        = $clog2(DEPTH + 1),
   localparam int PW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] d_in,
   input  logic                  r_en,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] d_out,
   output logic                  d_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CW-1:0]         count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
   localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count_q;
   logic                  wr_ok;
   logic                  rd_ok;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;

   assign wr_ok = w_en & ~full;
   assign rd_ok = r_en & ~empty;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= d_in;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (rd_ok) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         // A new error wins over a coincident clear.
         if (w_en && full) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (r_en && empty) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign d_out   = mem[rd_ptr];
   assign d_valid = ~empty;
`else
   logic [DATA_WIDTH-1:0] d_out_q;
   logic                  d_valid_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         d_out_q   <= '0;
         d_valid_q <= 1'b0;
      end else begin
         d_valid_q <= rd_ok;
         if (rd_ok) begin
            d_out_q <= mem[rd_ptr];
         end
      end
   end

   assign d_out   = d_out_q;
   assign d_valid = d_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// tb_sync_fifo_flags : directed self-checking bench, DEPTH 16 and DEPTH 5.
// Revision 1.0
// ============================================================================
module tb_sync_fifo_flags;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;

   logic        w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
   logic [15:0] d_in = '0;
   logic [15:0] d_out;
   logic        d_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0]  count;

   logic        w_en5 = 1'b0, r_en5 = 1'b0, clr_err5 = 1'b0;
   logic [15:0] d_in5 = '0;
   logic [15:0] d_out5;
   logic        d_valid5, full5, empty5, almost_full5, almost_empty5, overflow5, underflow5;
   logic [2:0]  count5;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] q[$];
   logic [15:0] q5[$];
   logic [15:0] exp_d;

   always #5 clk = ~clk;

   sync_fifo_flags #(.DATA_WIDTH(16), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) u_dut (
      .clk(clk), .resetn(resetn), .w_en(w_en), .d_in(d_in), .r_en(r_en),
      .clr_err(clr_err), .d_out(d_out), .d_valid(d_valid), .full(full),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   sync_fifo_flags #(.DATA_WIDTH(16), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
      .clk(clk), .resetn(resetn), .w_en(w_en5), .d_in(d_in5), .r_en(r_en5),
      .clr_err(clr_err5), .d_out(d_out5), .d_valid(d_valid5), .full(full5),
      .empty(empty5), .almost_full(almost_full5), .almost_empty(almost_empty5),
      .count(count5), .overflow(overflow5), .underflow(underflow5)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state();
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_afull", 32'(almost_full), 0);
      check("rst_aempty", 32'(almost_empty), 1);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_udf", 32'(underflow), 0);
      check("rst_dout", 32'(d_out), 0);
      check("rst_dvalid", 32'(d_valid), 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_reset_state();
      check("rst5_empty", 32'(empty5), 1);
      resetn = 1'b1;

      // Fill 16 words, watching threshold crossings.
      for (int i = 1; i <= 16; i++) begin
         w_en = 1'b1; d_in = 16'(i);
         tick();
         check("fill_count", 32'(count), 32'(i));
         if (i == 2)  check("aempty_at2", 32'(almost_empty), 1);
         if (i == 3)  check("aempty_at3", 32'(almost_empty), 0);
         if (i == 13) check("afull_at13", 32'(almost_full), 0);
         if (i == 14) check("afull_at14", 32'(almost_full), 1);
         if (i == 15) check("full_at15", 32'(full), 0);
      end
      check("full_at16", 32'(full), 1);

      // Write while full: dropped, overflow sticky until cleared.
      d_in = 16'hDEAD;
      tick();
      w_en = 1'b0;
      check("ovf_set", 32'(overflow), 1);
      check("ovf_count", 32'(count), 16);
      tick();
      check("ovf_sticky", 32'(overflow), 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("ovf_clr", 32'(overflow), 0);

      // Drain: data in order, one cycle after each accepted read.
      for (int i = 1; i <= 16; i++) begin
         r_en = 1'b1;
         tick();
         check("rd_valid", 32'(d_valid), 1);
         check("rd_data", 32'(d_out), 32'(i));
      end
      r_en = 1'b0;
      tick();
      check("rd_idle_valid", 32'(d_valid), 0);
      check("rd_hold_data", 32'(d_out), 16'h0010);
      check("drain_empty", 32'(empty), 1);
      check("drain_count", 32'(count), 0);

      // Read while empty.
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      check("udf_set", 32'(underflow), 1);
      check("udf_valid", 32'(d_valid), 0);
      check("udf_dout", 32'(d_out), 16'h0010);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("udf_clr", 32'(underflow), 0);

      // Both while empty: write taken, read rejected.
      w_en = 1'b1; r_en = 1'b1; d_in = 16'h0100;
      tick();
      r_en = 1'b0;
      q.push_back(16'h0100);
      check("both_empty_count", 32'(count), 1);
      check("both_empty_udf", 32'(underflow), 1);
      check("both_empty_valid", 32'(d_valid), 0);
      for (int i = 1; i <= 7; i++) begin
         d_in = 16'h0100 + 16'(i);
         q.push_back(d_in);
         tick();
      end
      check("mid_count", 32'(count), 8);

      // Sustained simultaneous traffic at count 8.
      r_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         d_in = 16'h0200 + 16'(k);
         tick();
         exp_d = q.pop_front();
         q.push_back(d_in);
         check("stream_count", 32'(count), 8);
         check("stream_valid", 32'(d_valid), 1);
         check("stream_data", 32'(d_out), 32'(exp_d));
      end
      r_en = 1'b0;
      clr_err = 1'b1;
      for (int k = 0; k < 8; k++) begin
         d_in = 16'h0300 + 16'(k);
         q.push_back(d_in);
         tick();
         clr_err = 1'b0;
      end
      check("refill_full", 32'(full), 1);
      check("refill_udf_clr", 32'(underflow), 0);

      // Both while full: read taken, write dropped.
      r_en = 1'b1; d_in = 16'hBEEF;
      tick();
      w_en = 1'b0; r_en = 1'b0;
      exp_d = q.pop_front();
      check("both_full_count", 32'(count), 15);
      check("both_full_ovf", 32'(overflow), 1);
      check("both_full_data", 32'(d_out), 32'(exp_d));

      // Asynchronous reset in the middle of a write burst.
      resetn = 1'b0; #2; resetn = 1'b1;
      tick();
      w_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d_in = 16'h0400 + 16'(i);
         tick();
      end
      #2;
      resetn = 1'b0;
      #1;
      check_reset_state();
      w_en = 1'b0;
      #1;
      resetn = 1'b1;
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
      check("post_rst_udf", 32'(underflow), 1);
      check("post_rst_valid", 32'(d_valid), 0);

      // DEPTH 5: pointer wrap with order preserved.
      for (int i = 0; i < 4; i++) begin
         w_en5 = 1'b1; d_in5 = 16'h0050 + 16'(i);
         q5.push_back(d_in5);
         tick();
      end
      check("d5_afull", 32'(almost_full5), 1);
      check("d5_not_full", 32'(full5), 0);
      r_en5 = 1'b1;
      for (int k = 0; k < 12; k++) begin
         d_in5 = 16'h0060 + 16'(k);
         tick();
         exp_d = q5.pop_front();
         q5.push_back(d_in5);
         check("d5_count", 32'(count5), 4);
         check("d5_data", 32'(d_out5), 32'(exp_d));
      end
      r_en5 = 1'b0;
      d_in5 = 16'h0070;
      q5.push_back(d_in5);
      tick();
      check("d5_full", 32'(full5), 1);
      d_in5 = 16'h0071;
      tick();
      w_en5 = 1'b0;
      check("d5_ovf", 32'(overflow5), 1);
      check("d5_count_cap", 32'(count5), 5);
      r_en5 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         exp_d = q5.pop_front();
         check("d5_drain", 32'(d_out5), 32'(exp_d));
      end
      r_en5 = 1'b0;
      check("d5_empty", 32'(empty5), 1);
      check("d5_aempty", 32'(almost_empty5), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
